pipe_mem_stage: RTL and testbench

//  MIPS pipeline memory-access stage, directly upstream of the writeback stage.

---
 rtl/pipe_mem_stage_if.sv | 40 ++++
 rtl/pipe_mem_stage.sv | 136 +++++++++++++
 tb/tb_pipe_mem_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_mem_stage_if.sv
// Bundle of the EX->MEM handshake, the data-memory port and the MEM->WB handshake.
// master: the memory stage itself. slave: the surrounding pipeline and memory.
interface pipe_mem_stage_if #(
  parameter int DW   = 32,
  parameter int IDXW = 5
);
  logic            up_syn;
  logic            up_ack;
  logic [DW-1:0]   alu_in;
  logic [DW-1:0]   sdata_in;
  logic [IDXW-1:0] idx_in;
  logic [2:0]      op_in;

  logic            mem_req;
  logic            mem_we;
  logic [DW-1:0]   mem_addr;
  logic [3:0]      mem_be;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  logic            down_syn;
  logic            down_ack;
  logic [DW-1:0]   dout;
  logic [IDXW-1:0] idxout;
  logic            wb_en;
  logic            align_err;

  modport master (
    input  up_syn, alu_in, sdata_in, idx_in, op_in, mem_rdata, mem_ack, down_ack,
    output up_ack, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           down_syn, dout, idxout, wb_en, align_err
  );

  modport slave (
    output up_syn, alu_in, sdata_in, idx_in, op_in, mem_rdata, mem_ack, down_ack,
    input  up_ack, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
           down_syn, dout, idxout, wb_en, align_err
  );
endinterface

// File: rtl/pipe_mem_stage.sv
// MIPS memory-access stage: one instruction in flight, syn/ack on both sides,
// byte/word loads and stores over a req/ack memory port. All outputs registered.
module pipe_mem_stage #(
  parameter int DW   = 32,
  parameter int IDXW = 5
) (
  input  logic clk,
  input  logic rst,
  pipe_mem_stage_if.master bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, SEND, DRAIN} state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LB   = 3'd3;
  localparam logic [2:0] OP_LBU  = 3'd4;
  localparam logic [2:0] OP_SB   = 3'd5;

  typedef struct packed {
    logic [2:0]      op;
    logic [1:0]      lane;
    logic [IDXW-1:0] idx;
  } req_t;

  state_t          state, state_n;
  req_t            req, req_n;
  logic            up_ack_n, mem_req_n, mem_we_n, down_syn_n, wb_en_n, align_err_n;
  logic [DW-1:0]   mem_addr_n, mem_wdata_n, dout_n;
  logic [3:0]      mem_be_n;
  logic [IDXW-1:0] idxout_n;

  logic [2:0] op_c;
  logic       is_word, is_byte, is_store, misalign;
  logic [7:0] rbyte;

  // Opcodes 6-7 collapse to NONE so they pass straight through like ALU ops.
  assign op_c     = (bus.op_in > OP_SB) ? OP_NONE : bus.op_in;
  assign is_word  = (op_c == OP_LW) || (op_c == OP_SW);
  assign is_byte  = (op_c == OP_LB) || (op_c == OP_LBU) || (op_c == OP_SB);
  assign is_store = (op_c == OP_SW) || (op_c == OP_SB);
  assign misalign = is_word && (bus.alu_in[1:0] != 2'b00);
  assign rbyte    = bus.mem_rdata[{req.lane, 3'b000} +: 8];

  always_comb begin
    state_n     = state;
    req_n       = req;
    up_ack_n    = bus.up_ack;
    mem_req_n   = bus.mem_req;
    mem_we_n    = bus.mem_we;
    mem_addr_n  = bus.mem_addr;
    mem_be_n    = bus.mem_be;
    mem_wdata_n = bus.mem_wdata;
    down_syn_n  = bus.down_syn;
    dout_n      = bus.dout;
    idxout_n    = bus.idxout;
    wb_en_n     = bus.wb_en;
    align_err_n = 1'b0;

    if (bus.up_ack && !bus.up_syn) up_ack_n = 1'b0;

    case (state)
      IDLE: if (bus.up_syn && !bus.up_ack) begin
        up_ack_n = 1'b1;
        req_n    = '{op: op_c, lane: bus.alu_in[1:0], idx: bus.idx_in};
        idxout_n = bus.idx_in;
        if ((is_word || is_byte) && !misalign) begin
          state_n     = ACCESS;
          mem_req_n   = 1'b1;
          mem_we_n    = is_store;
          mem_addr_n  = {bus.alu_in[DW-1:2], 2'b00};
          mem_be_n    = is_byte ? (4'b0001 << bus.alu_in[1:0]) : 4'hF;
          mem_wdata_n = (op_c == OP_SB) ? {(DW/8){bus.sdata_in[7:0]}} :
                        (op_c == OP_SW) ? bus.sdata_in : '0;
        end else begin
          state_n     = SEND;
          down_syn_n  = 1'b1;
          dout_n      = misalign ? '0 : bus.alu_in;
          wb_en_n     = !misalign && (bus.idx_in != '0);
          align_err_n = misalign;
        end
      end
      ACCESS: if (bus.mem_ack) begin
        state_n    = SEND;
        mem_req_n  = 1'b0;
        mem_we_n   = 1'b0;
        down_syn_n = 1'b1;
        wb_en_n    = (req.idx != '0);
        case (req.op)
          OP_LW:   dout_n = bus.mem_rdata;
          OP_LB:   dout_n = {{(DW-8){rbyte[7]}}, rbyte};
          OP_LBU:  dout_n = {{(DW-8){1'b0}}, rbyte};
          default: begin dout_n = '0; wb_en_n = 1'b0; end
        endcase
      end
      SEND: if (bus.down_ack) begin
        state_n    = DRAIN;
        down_syn_n = 1'b0;
      end
      DRAIN: if (!bus.down_ack) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      req           <= '0;
      bus.up_ack    <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.down_syn  <= 1'b0;
      bus.dout      <= '0;
      bus.idxout    <= '0;
      bus.wb_en     <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      state         <= state_n;
      req           <= req_n;
      bus.up_ack    <= up_ack_n;
      bus.mem_req   <= mem_req_n;
      bus.mem_we    <= mem_we_n;
      bus.mem_addr  <= mem_addr_n;
      bus.mem_be    <= mem_be_n;
      bus.mem_wdata <= mem_wdata_n;
      bus.down_syn  <= down_syn_n;
      bus.dout      <= dout_n;
      bus.idxout    <= idxout_n;
      bus.wb_en     <= wb_en_n;
      bus.align_err <= align_err_n;
    end
  end
endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: one task per scenario, expected values hand-computed.
module tb_pipe_mem_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pipe_mem_stage_if #(.DW(32), .IDXW(5)) bus();
  pipe_mem_stage #(.DW(32), .IDXW(5)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_req(input logic [2:0] op, input logic [31:0] alu, input logic [31:0] sdata,
                          input logic [4:0] idx, output logic req_at, output logic align_at);
    logic ok;
    ok = 1'b0;
    bus.op_in = op; bus.alu_in = alu; bus.sdata_in = sdata; bus.idx_in = idx;
    bus.up_syn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.up_ack) begin ok = 1'b1; break; end
    end
    req_at   = bus.mem_req;
    align_at = bus.align_err;
    bus.up_syn = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: up_ack=%0b required 1", bus.up_ack); end
    step();
  endtask

  task automatic serve_mem(input int delay, input logic [31:0] rdata, output logic [31:0] addr,
                           output logic [3:0] be, output logic we, output logic [31:0] wdata);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.mem_req) begin ok = 1'b1; break; end
      step();
    end
    addr = bus.mem_addr; be = bus.mem_be; we = bus.mem_we; wdata = bus.mem_wdata;
    checks++;
    if (!ok) begin errors++; $display("FAIL mem_req_timeout: mem_req=%0b required 1", bus.mem_req); end
    for (int i = 0; i < delay; i++) step();
    bus.mem_rdata = rdata; bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    checks++;
    if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mem_req_drop: got %0b required 0", bus.mem_req); end
  endtask

  task automatic take_down(output logic [31:0] dout, output logic [4:0] idx, output logic wb);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.down_syn) begin ok = 1'b1; break; end
      step();
    end
    dout = bus.dout; idx = bus.idxout; wb = bus.wb_en;
    checks++;
    if (!ok) begin errors++; $display("FAIL down_syn_timeout: down_syn=%0b required 1", bus.down_syn); end
    bus.down_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!bus.down_syn) break;
    end
    bus.down_ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.up_ack, bus.down_syn, bus.mem_req, bus.mem_we, bus.mem_be, bus.wb_en, bus.align_err} !== '0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.dout !== '0 || bus.idxout !== '0) begin
      errors++;
      $display("FAIL reset_outputs: up_ack=%0b down_syn=%0b mem_req=%0b dout=%h idxout=%0d required all 0",
               bus.up_ack, bus.down_syn, bus.mem_req, bus.dout, bus.idxout);
    end
    @(negedge clk) rst = 1'b1;
    step();
  endtask

  task automatic test_none();
    logic r, a, wb; logic [31:0] d; logic [4:0] ix;
    send_req(3'd0, 32'h1234, 32'h0, 5'd7, r, a);
    checks++;
    if (r !== 1'b0) begin errors++; $display("FAIL none_no_mem_req: got %0b required 0", r); end
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h1234 || ix !== 5'd7 || wb !== 1'b1) begin
      errors++; $display("FAIL none_payload: dout=%h idx=%0d wb=%0b required 00001234 7 1", d, ix, wb);
    end
    // idx 0 never writes the register file; opcode 7 behaves as NONE
    send_req(3'd7, 32'h55AA, 32'h0, 5'd0, r, a);
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h55AA || ix !== 5'd0 || wb !== 1'b0 || r !== 1'b0) begin
      errors++; $display("FAIL none_idx0: dout=%h idx=%0d wb=%0b req=%0b required 000055aa 0 0 0", d, ix, wb, r);
    end
  endtask

  task automatic test_lw();
    logic r, a, we, wb; logic [31:0] ad, wd, d; logic [3:0] be; logic [4:0] ix;
    send_req(3'd1, 32'h100, 32'h0, 5'd9, r, a);
    checks++;
    if (r !== 1'b1) begin errors++; $display("FAIL lw_req_at_accept: got %0b required 1", r); end
    serve_mem(3, 32'hDEADBEEF, ad, be, we, wd);
    checks++;
    if (ad !== 32'h100 || be !== 4'hF || we !== 1'b0) begin
      errors++; $display("FAIL lw_mem_port: addr=%h be=%h we=%0b required 00000100 f 0", ad, be, we);
    end
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'hDEADBEEF || ix !== 5'd9 || wb !== 1'b1) begin
      errors++; $display("FAIL lw_payload: dout=%h idx=%0d wb=%0b required deadbeef 9 1", d, ix, wb);
    end
  endtask

  task automatic test_lb_lbu();
    logic r, a, we, wb; logic [31:0] ad, wd, d; logic [3:0] be; logic [4:0] ix;
    send_req(3'd3, 32'h103, 32'h0, 5'd4, r, a);
    serve_mem(1, 32'h80112233, ad, be, we, wd);
    take_down(d, ix, wb);
    checks++;
    if (ad !== 32'h100 || we !== 1'b0 || d !== 32'hFFFFFF80 || wb !== 1'b1) begin
      errors++; $display("FAIL lb_sext: addr=%h we=%0b dout=%h wb=%0b required 00000100 0 ffffff80 1", ad, we, d, wb);
    end
    send_req(3'd4, 32'h103, 32'h0, 5'd4, r, a);
    serve_mem(0, 32'h80112233, ad, be, we, wd);
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h00000080 || wb !== 1'b1) begin
      errors++; $display("FAIL lbu_zext: dout=%h wb=%0b required 00000080 1", d, wb);
    end
  endtask

  task automatic test_stores();
    logic r, a, we, wb; logic [31:0] ad, wd, d; logic [3:0] be; logic [4:0] ix;
    send_req(3'd5, 32'h202, 32'h123456AB, 5'd6, r, a);
    serve_mem(2, 32'h0, ad, be, we, wd);
    checks++;
    if (ad !== 32'h200 || be !== 4'b0100 || we !== 1'b1 || wd !== 32'hABABABAB) begin
      errors++; $display("FAIL sb_mem_port: addr=%h be=%b we=%0b wdata=%h required 00000200 0100 1 abababab", ad, be, we, wd);
    end
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h0 || wb !== 1'b0) begin
      errors++; $display("FAIL sb_payload: dout=%h wb=%0b required 0 0", d, wb);
    end
    send_req(3'd2, 32'h300, 32'hCAFEF00D, 5'd1, r, a);
    serve_mem(1, 32'h0, ad, be, we, wd);
    take_down(d, ix, wb);
    checks++;
    if (ad !== 32'h300 || be !== 4'hF || we !== 1'b1 || wd !== 32'hCAFEF00D || wb !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL sw_access: addr=%h be=%h we=%0b wdata=%h wb=%0b dout=%h required 00000300 f 1 cafef00d 0 0",
                         ad, be, we, wd, wb, d);
    end
  endtask

  task automatic test_misaligned();
    logic r, a, wb, al_after; logic [31:0] d; logic [4:0] ix;
    send_req(3'd1, 32'h101, 32'h0, 5'd8, r, a);
    al_after = bus.align_err;
    checks++;
    if (r !== 1'b0 || a !== 1'b1 || al_after !== 1'b0) begin
      errors++; $display("FAIL misaligned_pulse: req=%0b align=%0b align_next=%0b required 0 1 0", r, a, al_after);
    end
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h0 || wb !== 1'b0 || ix !== 5'd8 || bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL misaligned_payload: dout=%h wb=%0b idx=%0d required 0 0 8", d, wb, ix);
    end
  endtask

  task automatic test_ignored_acks();
    bus.mem_ack = 1'b1; bus.down_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0; bus.down_ack = 1'b0;
    step();
    checks++;
    if (bus.down_syn !== 1'b0 || bus.mem_req !== 1'b0 || bus.up_ack !== 1'b0) begin
      errors++; $display("FAIL idle_acks_ignored: down_syn=%0b mem_req=%0b up_ack=%0b required 0 0 0",
                         bus.down_syn, bus.mem_req, bus.up_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic r, a, wb, blocked; logic [31:0] d; logic [4:0] ix;
    send_req(3'd0, 32'h11, 32'h0, 5'd3, r, a);
    bus.op_in = 3'd0; bus.alu_in = 32'h22; bus.idx_in = 5'd5; bus.up_syn = 1'b1;
    blocked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.up_ack || !bus.down_syn || bus.dout !== 32'h11) blocked = 1'b0;
    end
    checks++;
    if (!blocked) begin errors++; $display("FAIL backpressure_block: up_ack=%0b down_syn=%0b required 0 1", bus.up_ack, bus.down_syn); end
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h11 || ix !== 5'd3) begin errors++; $display("FAIL b2b_first: dout=%h idx=%0d required 00000011 3", d, ix); end
    for (int i = 0; i < 10; i++) begin
      if (bus.up_ack) break;
      step();
    end
    checks++;
    if (bus.up_ack !== 1'b1) begin errors++; $display("FAIL b2b_second_accept: up_ack=%0b required 1", bus.up_ack); end
    bus.up_syn = 1'b0;
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h22 || ix !== 5'd5 || wb !== 1'b1) begin
      errors++; $display("FAIL b2b_second: dout=%h idx=%0d wb=%0b required 00000022 5 1", d, ix, wb);
    end
  endtask

  task automatic test_reset_mid_access();
    logic r, a, wb; logic [31:0] d; logic [4:0] ix;
    send_req(3'd1, 32'h400, 32'h0, 5'd2, r, a);
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL access_pending: mem_req=%0b required 1", bus.mem_req); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.down_syn !== 1'b0 || bus.up_ack !== 1'b0) begin
      errors++; $display("FAIL async_reset: mem_req=%0b down_syn=%0b up_ack=%0b required 0 0 0",
                         bus.mem_req, bus.down_syn, bus.up_ack);
    end
    @(negedge clk) rst = 1'b1;
    step();
    send_req(3'd0, 32'h55, 32'h0, 5'd2, r, a);
    take_down(d, ix, wb);
    checks++;
    if (d !== 32'h55 || ix !== 5'd2 || wb !== 1'b1 || r !== 1'b0) begin
      errors++; $display("FAIL reset_recovery: dout=%h idx=%0d wb=%0b required 00000055 2 1", d, ix, wb);
    end
  endtask

  initial begin
    bus.up_syn = 1'b0; bus.alu_in = '0; bus.sdata_in = '0; bus.idx_in = '0; bus.op_in = '0;
    bus.mem_rdata = '0; bus.mem_ack = 1'b0; bus.down_ack = 1'b0;
    test_reset();
    test_none();
    test_lw();
    test_lb_lbu();
    test_stores();
    test_misaligned();
    test_ignored_acks();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
